// File: rtl/ysyx_22041752_rf_ctrl_pkg.sv
// ysyx_22041752_rf_ctrl_pkg: register-file geometry, scoreboard limits and write-port grant type
package ysyx_22041752_rf_ctrl_pkg;
    localparam int RF_NUM   = 32;
    localparam int ADDR_WD  = 5;
    localparam int DATA_WD  = 64;
    localparam int MAX_OUT  = 4;
    localparam int MAX_WAIT = 3;
    localparam int CNT_WD   = $clog2(MAX_OUT + 1);
    localparam int WAIT_WD  = $clog2(MAX_WAIT + 1);
    typedef logic [ADDR_WD-1:0] addr_t;
    typedef logic [DATA_WD-1:0] data_t;
    typedef logic [RF_NUM-1:0]  rmask_t;
    typedef enum logic {GNT_PIPE = 1'b0, GNT_LU = 1'b1} grant_e;
    function automatic rmask_t onehot(addr_t a);
        return rmask_t'(1) << a;
    endfunction
endpackage

// File: rtl/ysyx_22041752_rf_ctrl_if.sv
// ysyx_22041752_rf_ctrl_if: ID hazard query, both write-back sources and the register-file write port
interface ysyx_22041752_rf_ctrl_if;
    import ysyx_22041752_rf_ctrl_pkg::*;
    logic   id_valid;
    addr_t  id_rs1;
    addr_t  id_rs2;
    addr_t  id_rd;
    logic   id_rd_we;
    logic   id_is_long;
    logic   id_stall;
    logic   pipe_wb_valid;
    addr_t  pipe_wb_addr;
    data_t  pipe_wb_data;
    logic   pipe_wb_stall;
    logic   lu_wb_valid;
    addr_t  lu_wb_addr;
    data_t  lu_wb_data;
    logic   lu_wb_ready;
    logic   rf_we;
    addr_t  rf_addr_w;
    data_t  rf_data_w;
    rmask_t busy_vec;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_long,
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output lu_wb_valid, lu_wb_addr, lu_wb_data,
        input  id_stall, pipe_wb_stall, lu_wb_ready,
        input  rf_we, rf_addr_w, rf_data_w, busy_vec
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_long,
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  lu_wb_valid, lu_wb_addr, lu_wb_data,
        output id_stall, pipe_wb_stall, lu_wb_ready,
        output rf_we, rf_addr_w, rf_data_w, busy_vec
    );
endinterface

// File: rtl/ysyx_22041752_rf_scoreboard.sv
// ysyx_22041752_rf_scoreboard: pending-write bitmap, outstanding count and ID hazard detection
module ysyx_22041752_rf_scoreboard
    import ysyx_22041752_rf_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   id_valid_i,
    input  addr_t  id_rs1_i,
    input  addr_t  id_rs2_i,
    input  addr_t  id_rd_i,
    input  logic   id_rd_we_i,
    input  logic   id_is_long_i,
    input  logic   clr_valid_i,
    input  addr_t  clr_addr_i,
    output logic   id_stall_o,
    output rmask_t pending_o
);
    rmask_t pending_q, pending_d, set_mask, clr_mask;
    logic [CNT_WD-1:0] out_cnt_q, out_cnt_d;
    logic raw, waw, full, issue, clr_hit, dec;
    always_comb begin
        raw        = (id_rs1_i != '0 && pending_q[id_rs1_i]) || (id_rs2_i != '0 && pending_q[id_rs2_i]);
        waw        = id_rd_we_i && id_rd_i != '0 && pending_q[id_rd_i];
        full       = id_is_long_i && id_rd_we_i && out_cnt_q == CNT_WD'(MAX_OUT);
        id_stall_o = id_valid_i && (raw || waw || full);
        issue      = id_valid_i && !id_stall_o && id_is_long_i && id_rd_we_i && id_rd_i != '0;
        clr_hit    = clr_valid_i && clr_addr_i != '0 && pending_q[clr_addr_i];
        dec        = clr_hit && out_cnt_q != '0;
        set_mask   = issue ? onehot(id_rd_i) : '0;
        clr_mask   = clr_hit ? onehot(clr_addr_i) : '0;
        pending_d  = (pending_q & ~clr_mask) | set_mask;
        out_cnt_d  = out_cnt_q + CNT_WD'(issue) - CNT_WD'(dec);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            out_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            out_cnt_q <= out_cnt_d;
        end
    end
    assign pending_o = pending_q;
    // A completion must retire a register that was actually issued as long-latency.
    always_ff @(posedge clk) begin
        if (reset)
            assert (!(clr_valid_i && clr_addr_i != '0 && !pending_q[clr_addr_i]))
            else $error("rf_scoreboard: completion to non-pending x%0d", clr_addr_i);
    end
endmodule

// File: rtl/ysyx_22041752_rf_ctrl.sv
// ysyx_22041752_rf_ctrl: register-file write-port arbiter with starvation guard around the scoreboard
module ysyx_22041752_rf_ctrl
    import ysyx_22041752_rf_ctrl_pkg::*;
(
    input logic clk,
    input logic reset,
    ysyx_22041752_rf_ctrl_if.slave bus
);
    logic [WAIT_WD-1:0] wait_q, wait_d;
    logic force_q, force_d, lu_hs, blocked;
    grant_e gnt;
    ysyx_22041752_rf_scoreboard u_sb (
        .clk          (clk),
        .reset        (reset),
        .id_valid_i   (bus.id_valid),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_rd_i      (bus.id_rd),
        .id_rd_we_i   (bus.id_rd_we),
        .id_is_long_i (bus.id_is_long),
        .clr_valid_i  (lu_hs),
        .clr_addr_i   (bus.lu_wb_addr),
        .id_stall_o   (bus.id_stall),
        .pending_o    (bus.busy_vec)
    );
    // The long unit owns the port whenever forced or the pipeline has nothing to write.
    always_comb begin
        gnt               = (force_q || !bus.pipe_wb_valid) ? GNT_LU : GNT_PIPE;
        bus.lu_wb_ready   = gnt == GNT_LU;
        bus.pipe_wb_stall = force_q && bus.pipe_wb_valid;
        lu_hs             = bus.lu_wb_valid && bus.lu_wb_ready;
        blocked           = bus.lu_wb_valid && !bus.lu_wb_ready;
        bus.rf_we         = gnt == GNT_LU ? bus.lu_wb_valid : bus.pipe_wb_valid;
        bus.rf_addr_w     = gnt == GNT_LU ? bus.lu_wb_addr : bus.pipe_wb_addr;
        bus.rf_data_w     = gnt == GNT_LU ? bus.lu_wb_data : bus.pipe_wb_data;
        wait_d            = lu_hs ? '0 : blocked ? wait_q + WAIT_WD'(1) : wait_q;
        force_d           = !lu_hs && (force_q || wait_d == WAIT_WD'(MAX_WAIT));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q  <= '0;
            force_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            force_q <= force_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22041752_rf_ctrl.sv
// tb_ysyx_22041752_rf_ctrl: directed vectors and sequences for hazards, capacity, arbitration and x0
module tb_ysyx_22041752_rf_ctrl;
    import ysyx_22041752_rf_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    localparam data_t PIPE_D = 64'h1111_2222_3333_4444;
    localparam data_t LU_D   = 64'hAAAA_BBBB_CCCC_DDDD;
    ysyx_22041752_rf_ctrl_if bus ();
    ysyx_22041752_rf_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        int idv, rs1, rs2, rd, we, lng;
        int pv, pa, lv, la;
        int e_stall, e_pstall, e_rdy, e_we, e_addr, e_lu;
    } vec_t;
    vec_t tbl [13];
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic id_drive(input logic v, input int rs1, input int rs2, input int rd, input logic we, input logic lng);
        bus.id_valid = v;
        bus.id_rs1 = addr_t'(rs1);
        bus.id_rs2 = addr_t'(rs2);
        bus.id_rd = addr_t'(rd);
        bus.id_rd_we = we;
        bus.id_is_long = lng;
    endtask
    task automatic pipe_drive(input logic v, input int a, input data_t d);
        bus.pipe_wb_valid = v;
        bus.pipe_wb_addr = addr_t'(a);
        bus.pipe_wb_data = d;
    endtask
    task automatic lu_drive(input logic v, input int a, input data_t d);
        bus.lu_wb_valid = v;
        bus.lu_wb_addr = addr_t'(a);
        bus.lu_wb_data = d;
    endtask
    task automatic idle();
        id_drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pipe_drive(1'b0, 0, '0);
        lu_drive(1'b0, 0, '0);
    endtask
    task automatic issue_long(input int rd);
        id_drive(1'b1, 0, 0, rd, 1'b1, 1'b1);
        #2 chk("issue_no_stall", bus.id_stall, 0);
        cyc();
        idle();
    endtask
    task automatic complete(input int a);
        lu_drive(1'b1, a, LU_D);
        #2;
        chk("complete_ready", bus.lu_wb_ready, 1);
        chk("complete_addr", bus.rf_addr_w, a);
        cyc();
        idle();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        //       idv rs1 rs2 rd we lng pv pa lv la  stall pst rdy we addr lu
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1};
        tbl[1]  = '{1, 5, 0, 11, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
        tbl[2]  = '{1, 3, 5, 11, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
        tbl[3]  = '{1, 6, 3, 11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 1, 2, 7, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1};
        tbl[5]  = '{1, 1, 2, 7, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 7, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1};
        tbl[7]  = '{0, 5, 7, 7, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 1, 3, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 5,  0, 0, 0, 1, 3, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 1, 1, 5, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 0, 0, 1, 9, 0};
        // reset with long ops in flight and a partially counted starvation wait
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("por_busy", bus.busy_vec, 0);
        chk("por_ready", bus.lu_wb_ready, 1);
        reset = 1'b1;
        cyc();
        issue_long(9);
        issue_long(10);
        chk("inflight_busy", bus.busy_vec, 32'h0000_0600);
        pipe_drive(1'b1, 12, PIPE_D);
        lu_drive(1'b1, 9, LU_D);
        cyc();
        cyc();
        reset = 1'b0;
        idle();
        id_drive(1'b1, 9, 10, 11, 1'b1, 1'b0);
        #1;
        chk("rst_busy", bus.busy_vec, 0);
        chk("rst_stall", bus.id_stall, 0);
        chk("rst_ready", bus.lu_wb_ready, 1);
        chk("rst_pstall", bus.pipe_wb_stall, 0);
        repeat (2) cyc();
        chk("rst_hold_busy", bus.busy_vec, 0);
        idle();
        reset = 1'b1;
        cyc();
        // table vectors against pending {5,7}; inputs return to idle before each edge
        issue_long(5);
        issue_long(7);
        chk("tbl_busy", bus.busy_vec, 32'h0000_00A0);
        for (int i = 0; i < 13; i++) begin
            id_drive(tbl[i].idv != 0, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we != 0, tbl[i].lng != 0);
            pipe_drive(tbl[i].pv != 0, tbl[i].pa, PIPE_D);
            lu_drive(tbl[i].lv != 0, tbl[i].la, LU_D);
            #2;
            chk($sformatf("tbl%0d_stall", i), bus.id_stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_pstall", i), bus.pipe_wb_stall, tbl[i].e_pstall);
            chk($sformatf("tbl%0d_ready", i), bus.lu_wb_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_we", i), bus.rf_we, tbl[i].e_we);
            if (tbl[i].e_we != 0) begin
                chk($sformatf("tbl%0d_addr", i), bus.rf_addr_w, tbl[i].e_addr);
                chk($sformatf("tbl%0d_data", i), bus.rf_data_w, tbl[i].e_lu != 0 ? LU_D : PIPE_D);
            end
            #1 idle();
            cyc();
        end
        // arbitration: both sources held, the long unit is forced on the 4th cycle
        pipe_drive(1'b1, 12, PIPE_D);
        lu_drive(1'b1, 5, LU_D);
        for (int c = 1; c <= 3; c++) begin
            #2;
            chk($sformatf("arb_c%0d_addr", c), bus.rf_addr_w, 12);
            chk($sformatf("arb_c%0d_ready", c), bus.lu_wb_ready, 0);
            chk($sformatf("arb_c%0d_pstall", c), bus.pipe_wb_stall, 0);
            cyc();
        end
        #2;
        chk("arb_c4_ready", bus.lu_wb_ready, 1);
        chk("arb_c4_pstall", bus.pipe_wb_stall, 1);
        chk("arb_c4_we", bus.rf_we, 1);
        chk("arb_c4_addr", bus.rf_addr_w, 5);
        chk("arb_c4_data", bus.rf_data_w, LU_D);
        cyc();
        lu_drive(1'b1, 7, LU_D);
        #2;
        chk("arb_c5_addr", bus.rf_addr_w, 12);
        chk("arb_c5_ready", bus.lu_wb_ready, 0);
        chk("arb_c5_pstall", bus.pipe_wb_stall, 0);
        chk("arb_c5_busy", bus.busy_vec, 32'h0000_0080);
        cyc();
        idle();
        cyc();
        complete(7);
        chk("arb_drain_busy", bus.busy_vec, 0);
        // capacity and simultaneous issue/completion
        for (int k = 1; k <= 4; k++) issue_long(k);
        id_drive(1'b1, 0, 0, 6, 1'b1, 1'b1);
        #2;
        chk("cap_full_stall", bus.id_stall, 1);
        chk("cap_busy", bus.busy_vec, 32'h0000_001E);
        id_drive(1'b1, 0, 0, 6, 1'b1, 1'b0);
        #1 chk("cap_short_ok", bus.id_stall, 0);
        cyc();
        id_drive(1'b1, 0, 0, 6, 1'b1, 1'b1);
        lu_drive(1'b1, 1, LU_D);
        #2;
        chk("cap_full_on_hs", bus.id_stall, 1);
        chk("cap_hs_addr", bus.rf_addr_w, 1);
        cyc();
        lu_drive(1'b1, 2, LU_D);
        #2 chk("cap_issue_and_done", bus.id_stall, 0);
        cyc();
        idle();
        chk("cap_busy_swap", bus.busy_vec, 32'h0000_0058);
        issue_long(8);
        chk("cap_busy_refill", bus.busy_vec, 32'h0000_0158);
        id_drive(1'b1, 0, 0, 9, 1'b1, 1'b1);
        #2 chk("cap_full_again", bus.id_stall, 1);
        cyc();
        idle();
        complete(3);
        complete(4);
        complete(6);
        complete(8);
        chk("cap_drain_busy", bus.busy_vec, 0);
        // RAW: consumer of x5 waits for the long result, no bypass
        issue_long(5);
        id_drive(1'b1, 5, 0, 11, 1'b1, 1'b0);
        #2 chk("raw_stall", bus.id_stall, 1);
        cyc();
        #2 chk("raw_stall_hold", bus.id_stall, 1);
        cyc();
        lu_drive(1'b1, 5, 64'hDEAD_BEEF_0000_0005);
        #2;
        chk("raw_stall_hs", bus.id_stall, 1);
        chk("raw_hs_we", bus.rf_we, 1);
        chk("raw_hs_addr", bus.rf_addr_w, 5);
        chk("raw_hs_data", bus.rf_data_w, 64'hDEAD_BEEF_0000_0005);
        cyc();
        lu_drive(1'b0, 0, '0);
        #2;
        chk("raw_release", bus.id_stall, 0);
        chk("raw_busy", bus.busy_vec, 0);
        cyc();
        idle();
        // WAW: pipeline writer of x7 waits for the long write to x7
        issue_long(7);
        id_drive(1'b1, 1, 2, 7, 1'b1, 1'b0);
        #2 chk("waw_stall", bus.id_stall, 1);
        cyc();
        lu_drive(1'b1, 7, LU_D);
        #2 chk("waw_stall_hs", bus.id_stall, 1);
        cyc();
        lu_drive(1'b0, 0, '0);
        #2 chk("waw_release", bus.id_stall, 0);
        cyc();
        idle();
        // x0: never pending, never counted
        for (int k = 0; k < 4; k++) issue_long(0);
        chk("x0_busy", bus.busy_vec, 0);
        issue_long(1);
        chk("x0_cnt_busy", bus.busy_vec, 32'h0000_0002);
        id_drive(1'b1, 0, 0, 0, 1'b0, 1'b0);
        #2 chk("x0_rs_no_stall", bus.id_stall, 0);
        cyc();
        idle();
        complete(1);
        chk("final_busy", bus.busy_vec, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22041752_rf_ctrl.md
Name: ysyx_22041752_rf_ctrl

Overview:
Write-port arbiter and scoreboard for the integer register file. It sits beside the register file between the ID stage and the two write-back sources: the single-cycle pipeline WB and the long-latency unit (LSU/MDU). It tracks registers with outstanding long-latency writes, stalls ID on RAW/WAW hazards, and shares the single register-file write port with starvation protection.

Parameters:
RF_NUM, 32, number of architectural registers
ADDR_WD, 5, register address width
DATA_WD, 64, register data width
MAX_OUT, 4, maximum outstanding long-latency writes
MAX_WAIT, 3, cycles a blocked long-unit write waits before it is forced through

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds an instruction
id_rs1  in  ADDR_WD  source register 1
id_rs2  in  ADDR_WD  source register 2
id_rd  in  ADDR_WD  destination register
id_rd_we  in  1  instruction writes rd
id_is_long  in  1  rd is produced by the long-latency unit
id_stall  out  1  hold ID this cycle
pipe_wb_valid  in  1  pipeline write-back request
pipe_wb_addr  in  ADDR_WD  pipeline write-back address
pipe_wb_data  in  DATA_WD  pipeline write-back data
pipe_wb_stall  out  1  pipeline WB denied this cycle; hold WB and upstream
lu_wb_valid  in  1  long-unit write-back request
lu_wb_addr  in  ADDR_WD  long-unit write-back address
lu_wb_data  in  DATA_WD  long-unit write-back data
lu_wb_ready  out  1  long-unit write accepted
rf_we  out  1  register-file write enable
rf_addr_w  out  ADDR_WD  register-file write address
rf_data_w  out  DATA_WD  register-file write data
busy_vec  out  RF_NUM  pending-write bitmap, for debug/DPI

Behaviour:
- State:
  - pending[RF_NUM-1:0]
  - out_cnt, width clog2(MAX_OUT+1)
  - wait_cnt, width clog2(MAX_WAIT+1)
  - force flag
- Reset (reset=0, asynchronous): all state is 0. Outputs derived from it are therefore id_stall=0, pipe_wb_stall=0, lu_wb_ready=1 (pipe idle), busy_vec=0.
- Reset mid-operation discards all outstanding tracking. The long unit must be flushed by the same reset.
- Hazard (combinational): id_stall = id_valid & (raw | waw | full).
  - raw = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2])
  - waw = id_rd_we & rd!=0 & pending[rd]
  - full = id_is_long & id_rd_we & (out_cnt==MAX_OUT)
- Issue: id_fire = id_valid & ~id_stall. When id_fire & id_is_long & id_rd_we & rd!=0, set pending[rd] and increment out_cnt at the clock edge. x0 is never marked pending.
- Arbitration (combinational, one write per cycle):
  - force=0: pipeline wins. lu_wb_ready = ~pipe_wb_valid; pipe_wb_stall=0.
  - force=1: long unit wins. lu_wb_ready=1; pipe_wb_stall = pipe_wb_valid.
- Starvation counter:
  - wait_cnt increments each cycle lu_wb_valid & ~lu_wb_ready.
  - force is set the cycle after wait_cnt reaches MAX_WAIT, so the forced grant occurs on the (MAX_WAIT+1)th blocked cycle.
  - force and wait_cnt clear on the lu handshake.
- Write port: rf_we = granted source's valid. rf_addr_w and rf_data_w are muxed from the winner. A write to x0 is passed through; the register file ignores it.
- Completion: lu handshake (lu_wb_valid & lu_wb_ready) clears pending[lu_wb_addr] (unless 0) and decrements out_cnt at the edge.
  - The register-file write lands at the same edge, so dependents unstall the next cycle. There is no bypass.
- Simultaneous issue and completion in one cycle:
  - out_cnt is net unchanged.
  - Different addresses: the set and the clear both apply.
  - Same address cannot occur (waw stalls).
- A long-unit completion to a non-pending address is a protocol error. Flag it with a simulation assertion; pending is left unchanged and out_cnt does not underflow (saturate at 0).
- busy_vec = pending.

Decomposition:
- Shared package/header constants: ADDR_WD, DATA_WD, RF_NUM, MAX_OUT, MAX_WAIT defaults, added to the existing mycpu header.
- One natural sub-module: ysyx_22041752_rf_scoreboard. It holds pending, out_cnt and the hazard compare. The arbiter and starvation logic stay at top level.

Test Plan:
1. Reset: assert reset low for 2 cycles with long ops in flight -> busy_vec=0, out_cnt=0, lu_wb_ready=1, id_stall=0.
2. RAW: issue long rd=5, then ID rs1=5 -> id_stall=1 until lu_wb to 5 handshakes. Stall drops the following cycle and rf_addr_w=5 with the lu data on the handshake cycle.
3. Capacity: issue long rd=1,2,3,4 -> 5th long (rd=6) stalls. One completion and one issue in the same cycle -> out_cnt stays 4.
4. Arbitration: pipe_wb_valid and lu_wb_valid held every cycle.
   - Pipe writes for 3 cycles, then on the 4th cycle lu_wb_ready=1, pipe_wb_stall=1, rf_addr_w=lu addr.
   - Next cycle the pipe wins again.
5. x0 handling: long issue with rd=0 -> busy_vec unchanged, out_cnt unchanged. ID rs1=0 never stalls.
6. WAW: long rd=7 pending, pipe-writing instruction with rd=7 in ID -> stalls until rd=7 completes.
